// File: rtl/mips_id_core.sv
// ID stage: instruction decode, next-address calculation and 32x32 register file.
// Decode and reads are combinational; writeback is synchronous with async active-high clear.
module mips_id_core (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr,
    input  logic [31:0] Instr_PC_Plus4,
    input  logic [31:0] JumpRegValue,
    input  logic [4:0]  WriteReg,
    input  logic [31:0] WriteData,
    input  logic        Write,
    output logic        Link,
    output logic        RegDest,
    output logic        Jump,
    output logic        Branch,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        JumpRegister,
    output logic        SignOrZero,
    output logic        Syscall,
    output logic [5:0]  ALUControl,
    output logic [4:0]  WriteRegister,
    output logic [31:0] DataA,
    output logic [31:0] DataB,
    output logic [31:0] DataC,
    output logic [31:0] NextInstructionAddress
);
    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [31:0] w_br_off;
    logic [31:0] r_regs [0:31];

    assign w_op     = Instr[31:26];
    assign w_rs     = Instr[25:21];
    assign w_rt     = Instr[20:16];
    assign w_rd     = Instr[15:11];
    assign w_funct  = Instr[5:0];
    assign w_br_off = {{14{Instr[15]}}, Instr[15:0], 2'b00};

    always_comb begin
        Link         = 1'b0;
        RegDest      = 1'b0;
        Jump         = 1'b0;
        Branch       = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        ALUSrc       = 1'b0;
        RegWrite     = 1'b0;
        JumpRegister = 1'b0;
        SignOrZero   = 1'b0;
        Syscall      = 1'b0;
        ALUControl   = 6'h00;
        case (w_op)
            6'h00: begin
                case (w_funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B: begin
                        RegDest    = 1'b1;
                        RegWrite   = 1'b1;
                        ALUControl = w_funct;
                    end
                    6'h08: begin
                        Jump         = 1'b1;
                        JumpRegister = 1'b1;
                        ALUControl   = 6'h08;
                    end
                    6'h09: begin
                        Jump         = 1'b1;
                        JumpRegister = 1'b1;
                        Link         = 1'b1;
                        RegDest      = 1'b1;
                        RegWrite     = 1'b1;
                        ALUControl   = 6'h21;
                    end
                    6'h0C: begin
                        Syscall    = 1'b1;
                        ALUControl = 6'h0C;
                    end
                    default: ;
                endcase
            end
            6'h02: begin
                Jump       = 1'b1;
                ALUControl = 6'h21;
            end
            6'h03: begin
                Jump       = 1'b1;
                Link       = 1'b1;
                RegWrite   = 1'b1;
                ALUControl = 6'h21;
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                Branch     = 1'b1;
                SignOrZero = 1'b1;
                ALUControl = {4'hC, w_op[1:0]};
            end
            6'h01: begin
                // REGIMM: only BLTZ (rt=0) and BGEZ (rt=1) are supported
                if (w_rt == 5'd0 || w_rt == 5'd1) begin
                    Branch     = 1'b1;
                    SignOrZero = 1'b1;
                    ALUControl = (w_rt == 5'd0) ? 6'h34 : 6'h35;
                end
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                ALUSrc     = 1'b1;
                RegWrite   = 1'b1;
                SignOrZero = ~w_op[2];
                case (w_op[2:0])
                    3'd0:    ALUControl = 6'h20;
                    3'd1:    ALUControl = 6'h21;
                    3'd2:    ALUControl = 6'h2A;
                    3'd3:    ALUControl = 6'h2B;
                    3'd4:    ALUControl = 6'h24;
                    3'd5:    ALUControl = 6'h25;
                    3'd6:    ALUControl = 6'h26;
                    default: ALUControl = 6'h3C;
                endcase
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h30: begin
                MemRead    = 1'b1;
                RegWrite   = 1'b1;
                ALUSrc     = 1'b1;
                SignOrZero = 1'b1;
                ALUControl = (w_op == 6'h30) ? 6'h28 : 6'h21;
            end
            6'h28, 6'h29, 6'h2B: begin
                MemWrite   = 1'b1;
                ALUSrc     = 1'b1;
                SignOrZero = 1'b1;
                ALUControl = 6'h21;
            end
            6'h38: begin
                MemWrite   = 1'b1;
                RegWrite   = 1'b1;
                ALUSrc     = 1'b1;
                SignOrZero = 1'b1;
                ALUControl = 6'h36;
            end
            default: ;
        endcase
    end

    always_comb begin
        if (Jump && JumpRegister)
            NextInstructionAddress = JumpRegValue;
        else if (Jump)
            NextInstructionAddress = {Instr_PC_Plus4[31:28], Instr[25:0], 2'b00};
        else if (Branch)
            NextInstructionAddress = Instr_PC_Plus4 + w_br_off;
        else
            NextInstructionAddress = Instr_PC_Plus4;
    end

    assign WriteRegister = RegDest ? w_rd : (Link ? 5'd31 : w_rt);

    // No write-to-read bypass: a same-cycle write is only seen after the edge
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++)
                r_regs[i] <= 32'h0;
        end else if (Write && WriteReg != 5'd0) begin
            r_regs[WriteReg] <= WriteData;
        end
    end

    assign DataA = (w_rs == 5'd0) ? 32'h0 : r_regs[w_rs];
    assign DataB = (w_rt == 5'd0) ? 32'h0 : r_regs[w_rt];
    assign DataC = (WriteRegister == 5'd0) ? 32'h0 : r_regs[WriteRegister];
endmodule

// File: tb/tb_mips_id_core.sv
// Directed bench for mips_id_core: register file timing/reset and decode/next-address vectors.
module tb_mips_id_core;
    logic        CLK;
    logic        RESET;
    logic [31:0] Instr;
    logic [31:0] Instr_PC_Plus4;
    logic [31:0] JumpRegValue;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        Write;
    logic        Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc;
    logic        RegWrite, JumpRegister, SignOrZero, Syscall;
    logic [5:0]  ALUControl;
    logic [4:0]  WriteRegister;
    logic [31:0] DataA, DataB, DataC, NextInstructionAddress;
    logic [10:0] w_flags;

    int checks   = 0;
    int failures = 0;

    localparam logic [10:0] LNK = 11'h400, RDS = 11'h200, JMP = 11'h100, BRN = 11'h080;
    localparam logic [10:0] MRD = 11'h040, MWR = 11'h020, ASR = 11'h010, RWR = 11'h008;
    localparam logic [10:0] JRG = 11'h004, SOZ = 11'h002, SYS = 11'h001;

    mips_id_core dut (
        .CLK(CLK), .RESET(RESET), .Instr(Instr), .Instr_PC_Plus4(Instr_PC_Plus4),
        .JumpRegValue(JumpRegValue), .WriteReg(WriteReg), .WriteData(WriteData), .Write(Write),
        .Link(Link), .RegDest(RegDest), .Jump(Jump), .Branch(Branch), .MemRead(MemRead),
        .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .JumpRegister(JumpRegister),
        .SignOrZero(SignOrZero), .Syscall(Syscall), .ALUControl(ALUControl),
        .WriteRegister(WriteRegister), .DataA(DataA), .DataB(DataB), .DataC(DataC),
        .NextInstructionAddress(NextInstructionAddress)
    );

    assign w_flags = {Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc,
                      RegWrite, JumpRegister, SignOrZero, Syscall};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic test_reset();
        RESET = 1'b1; Write = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEADBEEF;
        Instr = 32'h0; Instr_PC_Plus4 = 32'h0; JumpRegValue = 32'h0;
        @(posedge CLK); @(posedge CLK);
        @(negedge CLK);
        for (int i = 0; i < 32; i++) begin
            Instr = {6'h0, i[4:0], 21'h0};
            #1;
            checks++;
            if (DataA !== 32'h0) begin
                failures++;
                $display("FAIL reset_read r%0d: got %h expected 00000000", i, DataA);
            end
        end
        @(negedge CLK);
        RESET = 1'b0; Write = 1'b0;
        Instr = {6'h0, 5'd5, 21'h0};
        #1;
        checks++;
        if (DataA !== 32'h0) begin
            failures++;
            $display("FAIL reset_blocks_write r5: got %h expected 00000000", DataA);
        end
    endtask

    task automatic test_write_visibility();
        @(negedge CLK);
        Write = 1'b1; WriteReg = 5'd5; WriteData = 32'h12345678;
        Instr = {6'h0, 5'd5, 5'd5, 16'h0};
        #1;
        checks++;
        if (DataA !== 32'h0) begin
            failures++;
            $display("FAIL write_before_edge: got %h expected 00000000", DataA);
        end
        @(posedge CLK); #1;
        checks++;
        if (DataA !== 32'h12345678) begin
            failures++;
            $display("FAIL write_after_edge DataA: got %h expected 12345678", DataA);
        end
        checks++;
        if (DataB !== 32'h12345678) begin
            failures++;
            $display("FAIL write_after_edge DataB: got %h expected 12345678", DataB);
        end
        @(negedge CLK);
        WriteReg = 5'd0; WriteData = 32'hFFFFFFFF;
        Instr = 32'h0;
        @(posedge CLK); #1;
        checks++;
        if (DataA !== 32'h0) begin
            failures++;
            $display("FAIL r0_write: got %h expected 00000000", DataA);
        end
        @(negedge CLK);
        WriteReg = 5'd7; WriteData = 32'hA5A50007;
        @(posedge CLK);
        @(negedge CLK);
        Write = 1'b0;
    endtask

    task automatic test_read_ports();
        @(negedge CLK);
        Instr = 32'h20A70000;   // ADDI rs=5 rt=7
        #1;
        checks++;
        if (WriteRegister !== 5'd7 || DataA !== 32'h12345678 || DataB !== 32'hA5A50007 || DataC !== 32'hA5A50007) begin
            failures++;
            $display("FAIL read_itype: wreg=%0d A=%h B=%h C=%h expected 7 12345678 a5a50007 a5a50007",
                     WriteRegister, DataA, DataB, DataC);
        end
        Instr = 32'h00053820;   // ADD rd=7 rs=0 rt=5
        #1;
        checks++;
        if (WriteRegister !== 5'd7 || DataA !== 32'h0 || DataB !== 32'h12345678 || DataC !== 32'hA5A50007) begin
            failures++;
            $display("FAIL read_rtype: wreg=%0d A=%h B=%h C=%h expected 7 00000000 12345678 a5a50007",
                     WriteRegister, DataA, DataB, DataC);
        end
    endtask

    task automatic test_jal();
        Instr = 32'h0C100004; Instr_PC_Plus4 = 32'h00400008;
        #1;
        checks++;
        if (w_flags !== (JMP | LNK | RWR) || WriteRegister !== 5'd31 || NextInstructionAddress !== 32'h00400010) begin
            failures++;
            $display("FAIL jal: flags=%h wreg=%0d nia=%h expected %h 31 00400010",
                     w_flags, WriteRegister, NextInstructionAddress, JMP | LNK | RWR);
        end
    endtask

    task automatic test_beq();
        Instr = 32'h1000FFFF; Instr_PC_Plus4 = 32'h00400100;
        #1;
        checks++;
        if (w_flags !== (BRN | SOZ) || ALUControl !== 6'h30 || NextInstructionAddress !== 32'h004000FC) begin
            failures++;
            $display("FAIL beq: flags=%h alu=%h nia=%h expected %h 30 004000fc",
                     w_flags, ALUControl, NextInstructionAddress, BRN | SOZ);
        end
    endtask

    task automatic test_jr();
        Instr = 32'h03E00008; JumpRegValue = 32'h00400ABC; Instr_PC_Plus4 = 32'h00000010;
        #1;
        checks++;
        if (w_flags !== (JMP | JRG) || RegWrite !== 1'b0 || NextInstructionAddress !== 32'h00400ABC) begin
            failures++;
            $display("FAIL jr: flags=%h nia=%h expected %h 00400abc", w_flags, NextInstructionAddress, JMP | JRG);
        end
    endtask

    task automatic test_next_addr();
        logic [31:0] ins [4];
        logic [31:0] pc  [4];
        logic [31:0] exp [4];
        ins[0] = 32'h0BFFFFFF; pc[0] = 32'hA0000004; exp[0] = 32'hAFFFFFFC;  // J, region kept
        ins[1] = 32'h14007FFF; pc[1] = 32'h00001000; exp[1] = 32'h00020FFC;  // BNE max forward
        ins[2] = 32'h10000001; pc[2] = 32'hFFFFFFFC; exp[2] = 32'h00000000;  // BEQ wraps
        ins[3] = 32'h20A70123; pc[3] = 32'h00400040; exp[3] = 32'h00400040;  // ADDI falls through
        for (int i = 0; i < 4; i++) begin
            Instr = ins[i]; Instr_PC_Plus4 = pc[i];
            #1;
            checks++;
            if (NextInstructionAddress !== exp[i]) begin
                failures++;
                $display("FAIL next_addr[%0d]: got %h expected %h", i, NextInstructionAddress, exp[i]);
            end
        end
    endtask

    task automatic test_decode_table();
        logic [31:0] ins [28];
        logic [10:0] flg [28];
        logic [5:0]  alu [28];
        ins[0]  = 32'h00430820; flg[0]  = RDS | RWR;             alu[0]  = 6'h20; // ADD
        ins[1]  = 32'h00000000; flg[1]  = RDS | RWR;             alu[1]  = 6'h00; // SLL
        ins[2]  = 32'h0043082B; flg[2]  = RDS | RWR;             alu[2]  = 6'h2B; // SLTU
        ins[3]  = 32'h00400809; flg[3]  = LNK|RDS|JMP|RWR|JRG;   alu[3]  = 6'h21; // JALR
        ins[4]  = 32'h00000001; flg[4]  = 11'h0;                 alu[4]  = 6'h00; // bad funct
        ins[5]  = 32'h08000000; flg[5]  = JMP;                   alu[5]  = 6'h21; // J
        ins[6]  = 32'h14000000; flg[6]  = BRN | SOZ;             alu[6]  = 6'h31; // BNE
        ins[7]  = 32'h18000000; flg[7]  = BRN | SOZ;             alu[7]  = 6'h32; // BLEZ
        ins[8]  = 32'h1C000000; flg[8]  = BRN | SOZ;             alu[8]  = 6'h33; // BGTZ
        ins[9]  = 32'h04000000; flg[9]  = BRN | SOZ;             alu[9]  = 6'h34; // BLTZ
        ins[10] = 32'h04010000; flg[10] = BRN | SOZ;             alu[10] = 6'h35; // BGEZ
        ins[11] = 32'h04020000; flg[11] = 11'h0;                 alu[11] = 6'h00; // REGIMM rt=2
        ins[12] = 32'h20000000; flg[12] = ASR | RWR | SOZ;       alu[12] = 6'h20; // ADDI
        ins[13] = 32'h24000000; flg[13] = ASR | RWR | SOZ;       alu[13] = 6'h21; // ADDIU
        ins[14] = 32'h28000000; flg[14] = ASR | RWR | SOZ;       alu[14] = 6'h2A; // SLTI
        ins[15] = 32'h2C000000; flg[15] = ASR | RWR | SOZ;       alu[15] = 6'h2B; // SLTIU
        ins[16] = 32'h30000000; flg[16] = ASR | RWR;             alu[16] = 6'h24; // ANDI
        ins[17] = 32'h34000000; flg[17] = ASR | RWR;             alu[17] = 6'h25; // ORI
        ins[18] = 32'h38000000; flg[18] = ASR | RWR;             alu[18] = 6'h26; // XORI
        ins[19] = 32'h3C000000; flg[19] = ASR | RWR;             alu[19] = 6'h3C; // LUI
        ins[20] = 32'h8C000000; flg[20] = MRD|RWR|ASR|SOZ;       alu[20] = 6'h21; // LW
        ins[21] = 32'h90000000; flg[21] = MRD|RWR|ASR|SOZ;       alu[21] = 6'h21; // LBU
        ins[22] = 32'hC0000000; flg[22] = MRD|RWR|ASR|SOZ;       alu[22] = 6'h28; // LL
        ins[23] = 32'hAC000000; flg[23] = MWR | ASR | SOZ;       alu[23] = 6'h21; // SW
        ins[24] = 32'hE0000000; flg[24] = MWR|RWR|ASR|SOZ;       alu[24] = 6'h36; // SC
        ins[25] = 32'hFC000000; flg[25] = 11'h0;                 alu[25] = 6'h00; // bad op
        ins[26] = 32'h88000000; flg[26] = 11'h0;                 alu[26] = 6'h00; // LWL unsupported
        ins[27] = 32'h0000000C; flg[27] = SYS;                   alu[27] = 6'h0C; // SYSCALL
        for (int i = 0; i < 28; i++) begin
            Instr = ins[i];
            #1;
            checks++;
            if (w_flags !== flg[i] || ALUControl !== alu[i]) begin
                failures++;
                $display("FAIL decode[%0d] instr=%h: flags=%h alu=%h expected flags=%h alu=%h",
                         i, ins[i], w_flags, ALUControl, flg[i], alu[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        Write = 1'b1; WriteReg = 5'd9; WriteData = 32'h00000099;
        Instr = {6'h0, 5'd5, 5'd9, 16'h0};
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if (DataA !== 32'h0) begin
            failures++;
            $display("FAIL async_clear r5: got %h expected 00000000", DataA);
        end
        @(posedge CLK); #1;
        checks++;
        if (DataB !== 32'h0) begin
            failures++;
            $display("FAIL write_during_reset r9: got %h expected 00000000", DataB);
        end
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        checks++;
        if (DataB !== 32'h0) begin
            failures++;
            $display("FAIL before_first_edge r9: got %h expected 00000000", DataB);
        end
        @(posedge CLK); #1;
        checks++;
        if (DataB !== 32'h00000099) begin
            failures++;
            $display("FAIL first_write_after_reset r9: got %h expected 00000099", DataB);
        end
        @(negedge CLK);
        Write = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_visibility();
        test_read_ports();
        test_jal();
        test_beq();
        test_jr();
        test_next_addr();
        test_decode_table();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
